// File: rtl/pipelined_adder.sv
// Pipelined ripple-carry adder: WIDTH bits split into STAGES chunks, one chunk per clock,
// valid/ready on both sides. Define ALU_SUB_EN to add the sub port (num_1 - num_2).
module pipelined_adder #(
   parameter int WIDTH  = 8,
   parameter int STAGES = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] num_1,
   input  logic [WIDTH-1:0] num_2,
   input  logic             c,
`ifdef ALU_SUB_EN
   input  logic             sub,
`endif
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             carry,
   output logic             overflow
);

   localparam int CHUNK = WIDTH / STAGES;

   // Bit offset of stage k's forwarded operand bits / resolved sum bits in the flat buses.
   function automatic int fwd_off(input int k);
      int o;
      o = 0;
      for (int j = 0; j < k; j++) o += WIDTH - (j + 1) * CHUNK;
      return o;
   endfunction

   function automatic int sum_off(input int k);
      int o;
      o = 0;
      for (int j = 0; j < k; j++) o += (j + 1) * CHUNK;
      return o;
   endfunction

   localparam int FWD_RAW  = fwd_off(STAGES - 1);
   localparam int FWD_BITS = (FWD_RAW > 0) ? FWD_RAW : 1;
   localparam int SUM_BITS = sum_off(STAGES);

   logic                advance;
   logic [WIDTH-1:0]    opb_eff;
   logic                cin_eff;
   logic [STAGES-1:0]   stg_vld;
   logic [STAGES-1:0]   stg_cy;
   logic [SUM_BITS-1:0] stg_sum;
   logic [FWD_BITS-1:0] stg_a;
   logic [FWD_BITS-1:0] stg_b;

`ifdef ALU_SUB_EN
   // Subtract as num_1 + ~num_2 + 1; the external carry-in is ignored in that mode.
   assign opb_eff = sub ? ~num_2 : num_2;
   assign cin_eff = sub | c;
`else
   assign opb_eff = num_2;
   assign cin_eff = c;
`endif

   assign advance  = out_ready | ~out_valid;
   assign in_ready = advance;

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      localparam int IW = WIDTH - k * CHUNK;
      localparam int SW = (k + 1) * CHUNK;

      logic           v_in;
      logic           cy_in;
      logic [IW-1:0]  a_in;
      logic [IW-1:0]  b_in;
      logic [CHUNK:0] chunk_add;
      logic [SW-1:0]  sum_d;
      logic           vld_q;
      logic           cy_q;
      logic [SW-1:0]  sum_q;

      if (k == 0) begin : g_first
         assign v_in  = in_valid;
         assign cy_in = cin_eff;
         assign a_in  = num_1;
         assign b_in  = opb_eff;
         assign sum_d = chunk_add[CHUNK-1:0];
      end else begin : g_next
         localparam int PF = fwd_off(k - 1);
         localparam int PS = sum_off(k - 1);
         assign v_in  = stg_vld[k-1];
         assign cy_in = stg_cy[k-1];
         assign a_in  = stg_a[PF +: IW];
         assign b_in  = stg_b[PF +: IW];
         assign sum_d = {chunk_add[CHUNK-1:0], stg_sum[PS +: k*CHUNK]};
      end

      assign chunk_add = {1'b0, a_in[CHUNK-1:0]} + {1'b0, b_in[CHUNK-1:0]}
                       + {{CHUNK{1'b0}}, cy_in};

      // Bubbles move the valid bit only; data registers keep their last contents.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            vld_q <= 1'b0;
            cy_q  <= 1'b0;
            sum_q <= '0;
         end else if (advance) begin
            vld_q <= v_in;
            if (v_in) begin
               cy_q  <= chunk_add[CHUNK];
               sum_q <= sum_d;
            end
         end
      end

      assign stg_vld[k]                = vld_q;
      assign stg_cy[k]                 = cy_q;
      assign stg_sum[sum_off(k) +: SW] = sum_q;

      if (k < STAGES - 1) begin : g_fwd
         localparam int RW = IW - CHUNK;
         logic [RW-1:0] a_q;
         logic [RW-1:0] b_q;

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               a_q <= '0;
               b_q <= '0;
            end else if (advance && v_in) begin
               a_q <= a_in[IW-1:CHUNK];
               b_q <= b_in[IW-1:CHUNK];
            end
         end

         assign stg_a[fwd_off(k) +: RW] = a_q;
         assign stg_b[fwd_off(k) +: RW] = b_q;
      end else begin : g_last
         logic ovf_q;

         // Carry into the MSB is recovered as a ^ b ^ sum at that bit.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               ovf_q <= 1'b0;
            end else if (advance && v_in) begin
               ovf_q <= a_in[IW-1] ^ b_in[IW-1] ^ chunk_add[CHUNK-1] ^ chunk_add[CHUNK];
            end
         end

         assign overflow = ovf_q;
      end
   end

   if (FWD_RAW == 0) begin : g_no_fwd
      assign stg_a = '0;
      assign stg_b = '0;
   end

   assign out_valid = stg_vld[STAGES-1];
   assign carry     = stg_cy[STAGES-1];
   assign sum       = stg_sum[sum_off(STAGES - 1) +: WIDTH];

endmodule
